eight_bit_wallace_final_accumulator: RTL



---
 rtl/wallace_acc_pkg.sv | 24 ++
 rtl/one_bit_full_adder.sv | 21 ++
 rtl/wallace_final_cpa.sv | 38 +++
 rtl/eight_bit_wallace_final_accumulator.sv | 125 ++++++++++++
 4 files changed

// File: rtl/wallace_acc_pkg.sv
// ============================================================================
// Module : wallace_acc_pkg
// Brief  : Shared widths and FSM state encoding for the Wallace final
//          accumulator slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wallace_acc_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/one_bit_full_adder.sv
// ============================================================================
// Module : one_bit_full_adder
// Brief  : Single-bit full adder cell used to build ripple chains.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/wallace_final_cpa.sv
// ============================================================================
// Module : wallace_final_cpa
// Brief  : Ripple carry-propagate adder resolving the Wallace sum/carry rows.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wallace_final_cpa
  import wallace_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] sum,
  output logic              cout
);

  // carry[i] is the carry into bit i; the chain starts with no carry-in
  logic [PROD_W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < PROD_W; i++) begin : g_bit
    one_bit_full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[PROD_W];

endmodule

`default_nettype wire

// File: rtl/eight_bit_wallace_final_accumulator.sv
// ============================================================================
// Module : eight_bit_wallace_final_accumulator
// Brief  : Stages Wallace sum/carry rows, resolves them with a ripple CPA and
//          accumulates a host-specified number of products; the total is
//          returned through a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eight_bit_wallace_final_accumulator
  import wallace_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] sum_row,
  input  logic [PROD_W-1:0] carry_row,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_result,
  output logic              overflow,
  output logic              cpa_carry,
  output logic              busy
);

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic               stage_valid;
  logic [PROD_W-1:0]  stage_sum;
  logic [PROD_W-1:0]  stage_carry;
  logic [ACC_W-1:0]   acc;
  logic               acc_ovf;
  logic               cpa_seen;

  logic [PROD_W-1:0]  product;
  logic               product_cout;
  logic [ACC_W:0]     product_ext;
  logic [ACC_W:0]     acc_next;

  wallace_final_cpa #(
    .PROD_W (PROD_W)
  ) u_cpa (
    .a    (stage_sum),
    .b    (stage_carry),
    .sum  (product),
    .cout (product_cout)
  );

  // Zero-extend the truncated product and add with one guard bit for overflow
  always_comb begin
    product_ext                = '0;
    product_ext[PROD_W-1:0]    = product;
    acc_next                   = {1'b0, acc} + product_ext;
  end

  // FSM, beat counter, stage register, accumulator and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      stage_valid <= 1'b0;
      stage_sum   <= '0;
      stage_carry <= '0;
      acc         <= '0;
      acc_ovf     <= 1'b0;
      cpa_seen    <= 1'b0;
    end else begin
      // Staged data is consumed exactly once; the bit is re-armed only by a new beat
      stage_valid <= 1'b0;
      if (stage_valid) begin
        acc <= acc_next[ACC_W-1:0];
        if (acc_next[ACC_W]) acc_ovf  <= 1'b1;
        if (product_cout)    cpa_seen <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            acc         <= '0;
            acc_ovf     <= 1'b0;
            cpa_seen    <= 1'b0;
            stage_valid <= 1'b0;
            remaining   <= len;
            state       <= (len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            stage_sum   <= sum_row;
            stage_carry <= carry_row;
            stage_valid <= 1'b1;
            remaining   <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last staged product is absorbed by the shared add above
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (acc_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free
  assign in_ready   = (state == ST_RUN);
  assign acc_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign acc_result = acc;
  assign overflow   = acc_ovf;
  assign cpa_carry  = cpa_seen;

endmodule

`default_nettype wire
